// File: rtl/ps2_mouse_packet_decoder.sv
// PS/2 mouse packet decoder: assembles 3-byte packets from the controller byte stream
// and publishes buttons, signed deltas and a clamped absolute cursor position.
module ps2_mouse_packet_decoder #(
    parameter int X_MAX          = 159,
    parameter int Y_MAX          = 119,
    parameter int X_INIT         = 80,
    parameter int Y_INIT         = 60,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic               CLOCK_50,
    input  logic               resetn,
    input  logic [7:0]         received_data,
    input  logic               received_data_en,
    output logic               packet_valid,
    output logic [2:0]         buttons,
    output logic signed [8:0]  dx,
    output logic signed [8:0]  dy,
    output logic [11:0]        cursor_x,
    output logic [11:0]        cursor_y,
    output logic               sync_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_B0, S_B1, S_B2} state_t;

    state_t         state, state_nxt;
    logic           ack_pending;
    logic [TW-1:0]  timer;
    logic           timeout;
    logic           take_ack, take_bad, take_hdr, take_x, take_y;

    // Header bits kept: {y_ovf, x_ovf, y_sign, x_sign, buttons[2:0]}
    logic [6:0]     hdr_p0;
    logic [7:0]     xbyte_p0;
    logic [7:0]     ybyte_p0;
    logic           vld_p0;

    logic signed [8:0]  dx_nxt, dy_nxt;
    logic signed [12:0] sum_x, sum_y;

    function automatic logic [11:0] clamp_pos(input logic signed [12:0] v, input int max);
        if (v < 13'sd0)
            return 12'd0;
        else if (int'(v) > max)
            return 12'(max);
        else
            return v[11:0];
    endfunction

    assign timeout = (state != S_B0) && !received_data_en && (timer == TW'(TIMEOUT_CYCLES));

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn)
            state <= S_B0;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_B0: if (take_hdr) state_nxt = S_B1;
            S_B1: if (received_data_en) state_nxt = S_B2;
                  else if (timeout) state_nxt = S_B0;
            S_B2: if (received_data_en || timeout) state_nxt = S_B0;
            default: state_nxt = S_B0;
        endcase
    end

    always_comb begin
        take_ack = 1'b0;
        take_bad = 1'b0;
        take_hdr = 1'b0;
        take_x   = 1'b0;
        take_y   = 1'b0;
        case (state)
            S_B0: if (received_data_en) begin
                // The controller's ACK to the enable command arrives once before data
                if (received_data == 8'hFA && ack_pending)
                    take_ack = 1'b1;
                else if (!received_data[3])
                    take_bad = 1'b1;
                else
                    take_hdr = 1'b1;
            end
            S_B1: take_x = received_data_en;
            S_B2: take_y = received_data_en;
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            ack_pending <= 1'b1;
            timer       <= '0;
            sync_err    <= 1'b0;
            vld_p0      <= 1'b0;
        end else begin
            if (take_ack || take_hdr)
                ack_pending <= 1'b0;
            if (received_data_en || state == S_B0 || timeout)
                timer <= '0;
            else if (timer != TW'(TIMEOUT_CYCLES))
                timer <= timer + TW'(1);
            sync_err <= take_bad || timeout;
            vld_p0   <= take_y;
        end
    end

    // Stage p0: capture packet bytes
    always_ff @(posedge CLOCK_50) begin
        if (take_hdr)
            hdr_p0 <= {received_data[7:4], received_data[2:0]};
        if (take_x)
            xbyte_p0 <= received_data;
        if (take_y)
            ybyte_p0 <= received_data;
    end

    assign dx_nxt = hdr_p0[5] ? 9'sd0 : $signed({hdr_p0[3], xbyte_p0});
    assign dy_nxt = hdr_p0[6] ? 9'sd0 : $signed({hdr_p0[4], ybyte_p0});
    assign sum_x  = $signed({1'b0, cursor_x}) + $signed({{4{dx_nxt[8]}}, dx_nxt});
    assign sum_y  = $signed({1'b0, cursor_y}) - $signed({{4{dy_nxt[8]}}, dy_nxt});

    // Stage p1: publish decoded packet and move the cursor
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            packet_valid <= 1'b0;
            buttons      <= 3'd0;
            dx           <= 9'sd0;
            dy           <= 9'sd0;
            cursor_x     <= 12'(X_INIT);
            cursor_y     <= 12'(Y_INIT);
        end else begin
            packet_valid <= vld_p0;
            if (vld_p0) begin
                buttons  <= hdr_p0[2:0];
                dx       <= dx_nxt;
                dy       <= dy_nxt;
                cursor_x <= clamp_pos(sum_x, X_MAX);
                cursor_y <= clamp_pos(sum_y, Y_MAX);
            end
        end
    end

endmodule
